// File: rtl/mem4x4_ctrl_pkg.sv
// Shared constants and types for the 4-word x 4-bit register-file controller.
// Opcode encodings match the host command bus; states are the controller FSM.
package mem4x4_ctrl_pkg;

    localparam int WORD_W = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        FILL,
        RD,
        RSP,
        DUMP_RD,
        DUMP_RSP
    } state_t;

endpackage

// File: rtl/mem4x4_ctrl.sv
// Command/response controller for a 4x4 register file: single writes, fills,
// single reads and a full dump, with a held response handshake to the host.
module mem4x4_ctrl
    import mem4x4_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [1:0]  cmdOp,
    input  logic [1:0]  cmdAdd,
    input  logic [3:0]  cmdData,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [1:0]  rspAdd,
    output logic [3:0]  rspData,
    output logic        memCe,
    output logic        memWe,
    output logic [1:0]  memAdd,
    output logic [3:0]  memDIn,
    input  logic [15:0] memDOut,
    output logic        busy
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_counter;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_add;
    logic [WORD_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_rspAdd;
    logic [WORD_W-1:0]   r_rspData;

    state_t              w_nextState;
    logic [ADDR_W-1:0]   w_nextCounter;
    logic                w_accept;
    logic                w_capture;
    logic [ADDR_W-1:0]   w_capAdd;
    logic [WORD_W-1:0]   w_capData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_op      <= '0;
            r_add     <= '0;
            r_data    <= '0;
            r_rspAdd  <= '0;
            r_rspData <= '0;
        end else begin
            r_state   <= w_nextState;
            r_counter <= w_nextCounter;
            if (w_accept) begin
                r_op   <= cmdOp;
                r_add  <= cmdAdd;
                r_data <= cmdData;
            end
            if (w_capture) begin
                r_rspAdd  <= w_capAdd;
                r_rspData <= w_capData;
            end
        end
    end

    // Reads sample memDOut combinationally in RD/DUMP_RD, so a write that
    // landed on the previous edge is already visible.
    always_comb begin
        w_nextState   = r_state;
        w_nextCounter = r_counter;
        w_capture     = 1'b0;
        w_capAdd      = r_add;
        cmdReady      = (r_state == IDLE) && !rst;
        w_accept      = cmdValid && cmdReady;
        busy          = (r_state != IDLE);
        rspValid      = (r_state == RSP) || (r_state == DUMP_RSP);
        memCe         = (r_state == WR) || (r_state == FILL);
        memWe         = memCe;
        memAdd        = (r_op == OP_FILL) ? r_counter : r_add;
        memDIn        = r_data;
        rspAdd        = r_rspAdd;
        rspData       = r_rspData;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextCounter = '0;
                    case (cmdOp)
                        OP_WRITE: w_nextState = WR;
                        OP_READ:  w_nextState = RD;
                        OP_FILL:  w_nextState = FILL;
                        default:  w_nextState = DUMP_RD;
                    endcase
                end
            end
            WR: w_nextState = IDLE;
            FILL: begin
                w_nextCounter = r_counter + 2'd1;
                if (r_counter == 2'd3) w_nextState = IDLE;
            end
            RD: begin
                w_capture   = 1'b1;
                w_nextState = RSP;
            end
            RSP: begin
                if (rspReady) w_nextState = IDLE;
            end
            DUMP_RD: begin
                w_capture   = 1'b1;
                w_capAdd    = r_counter;
                w_nextState = DUMP_RSP;
            end
            DUMP_RSP: begin
                if (rspReady) begin
                    w_nextCounter = r_counter + 2'd1;
                    w_nextState   = (r_counter == 2'd3) ? IDLE : DUMP_RD;
                end
            end
            default: w_nextState = IDLE;
        endcase

        w_capData = memDOut[{w_capAdd, 2'b00} +: WORD_W];
    end

endmodule

// File: tb/tb_mem4x4_ctrl.sv
// Directed bench for mem4x4_ctrl with a behavioural register file that
// records every write strobe; memDOut can be overridden for read patterns.
module tb_mem4x4_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [1:0]  cmdAdd;
    logic [3:0]  cmdData;
    logic        rspValid;
    logic        rspReady;
    logic [1:0]  rspAdd;
    logic [3:0]  rspData;
    logic        memCe;
    logic        memWe;
    logic [1:0]  memAdd;
    logic [3:0]  memDIn;
    logic [15:0] memDOut;
    logic        busy;

    logic [15:0] tbRegFile = 16'h0000;
    logic        useOverride;
    logic [15:0] overrideVal;
    int          testsRun = 0;
    int          testsFailed = 0;

    mem4x4_ctrl dut (
        .clk(clk), .rst(rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
        .cmdAdd(cmdAdd), .cmdData(cmdData),
        .rspValid(rspValid), .rspReady(rspReady), .rspAdd(rspAdd), .rspData(rspData),
        .memCe(memCe), .memWe(memWe), .memAdd(memAdd), .memDIn(memDIn),
        .memDOut(memDOut), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memCe && memWe) tbRegFile[{memAdd, 2'b00} +: 4] <= memDIn;
    end

    assign memDOut = useOverride ? overrideVal : tbRegFile;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op,
                                 input logic [1:0] ad, input logic [3:0] d);
        cmdValid = v;
        cmdOp    = op;
        cmdAdd   = ad;
        cmdData  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        rspReady = 1'b0;
        useOverride = 1'b0;
        overrideVal = 16'h0000;
        applyStimulus(1'b0, 2'b00, 2'd0, 4'h0);
        tick();
        tick();

        // reset state
        checkOutput("rst_cmdReady", {15'd0, cmdReady}, 16'd0);
        checkOutput("rst_busy", {15'd0, busy}, 16'd0);
        checkOutput("rst_rspValid", {15'd0, rspValid}, 16'd0);
        checkOutput("rst_memCeWe", {14'd0, memCe, memWe}, 16'd0);
        checkOutput("rst_memAdd", {14'd0, memAdd}, 16'd0);
        checkOutput("rst_memDIn", {12'd0, memDIn}, 16'd0);
        checkOutput("rst_rspAddData", {10'd0, rspAdd, rspData}, 16'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_cmdReady", {15'd0, cmdReady}, 16'd1);

        // WRITE add=2 data=A
        applyStimulus(1'b1, 2'b00, 2'd2, 4'hA);
        tick();
        applyStimulus(1'b0, 2'b00, 2'd0, 4'h0);
        checkOutput("wr_strobe", {14'd0, memCe, memWe}, 16'd3);
        checkOutput("wr_memAdd", {14'd0, memAdd}, 16'd2);
        checkOutput("wr_memDIn", {12'd0, memDIn}, 16'hA);
        checkOutput("wr_cmdReady", {15'd0, cmdReady}, 16'd0);
        checkOutput("wr_busy", {15'd0, busy}, 16'd1);
        checkOutput("wr_rspValid", {15'd0, rspValid}, 16'd0);
        tick();
        checkOutput("wr_done_cmdReady", {15'd0, cmdReady}, 16'd1);
        checkOutput("wr_done_memWe", {15'd0, memWe}, 16'd0);
        checkOutput("wr_done_rspValid", {15'd0, rspValid}, 16'd0);
        checkOutput("wr_regfile", tbRegFile, 16'h0A00);

        // READ add=2
        applyStimulus(1'b1, 2'b01, 2'd2, 4'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 2'd0, 4'h0);
        checkOutput("rd_rspValid_early", {15'd0, rspValid}, 16'd0);
        checkOutput("rd_memWe", {15'd0, memWe}, 16'd0);
        tick();
        checkOutput("rd_rspValid", {15'd0, rspValid}, 16'd1);
        checkOutput("rd_rspAdd", {14'd0, rspAdd}, 16'd2);
        checkOutput("rd_rspData", {12'd0, rspData}, 16'hA);
        useOverride = 1'b1;
        overrideVal = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rd_hold_valid", {15'd0, rspValid}, 16'd1);
            checkOutput("rd_hold_data", {10'd0, rspAdd, rspData}, {10'd0, 2'd2, 4'hA});
        end
        useOverride = 1'b0;
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput("rd_clear", {15'd0, rspValid}, 16'd0);
        checkOutput("rd_idle", {15'd0, cmdReady}, 16'd1);

        // FILL data=5 with a READ held pending
        applyStimulus(1'b1, 2'b10, 2'd3, 4'h5);
        tick();
        applyStimulus(1'b1, 2'b01, 2'd1, 4'hF);
        for (int k = 0; k < 4; k++) begin
            checkOutput("fill_strobe", {14'd0, memCe, memWe}, 16'd3);
            checkOutput("fill_memAdd", {14'd0, memAdd}, k[15:0]);
            checkOutput("fill_memDIn", {12'd0, memDIn}, 16'h5);
            checkOutput("fill_cmdReady", {15'd0, cmdReady}, 16'd0);
            tick();
        end
        checkOutput("fill_done_memWe", {15'd0, memWe}, 16'd0);
        checkOutput("fill_done_cmdReady", {15'd0, cmdReady}, 16'd1);
        checkOutput("fill_regfile", tbRegFile, 16'h5555);
        tick();
        applyStimulus(1'b0, 2'b00, 2'd0, 4'h0);
        checkOutput("held_rd_busy", {15'd0, busy}, 16'd1);
        tick();
        checkOutput("held_rd_rspValid", {15'd0, rspValid}, 16'd1);
        checkOutput("held_rd_rsp", {10'd0, rspAdd, rspData}, {10'd0, 2'd1, 4'h5});
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput("held_rd_clear", {15'd0, rspValid}, 16'd0);

        // DUMP with memDOut=4321 and rspReady held high
        useOverride = 1'b1;
        overrideVal = 16'h4321;
        rspReady = 1'b1;
        applyStimulus(1'b1, 2'b11, 2'd0, 4'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 2'd0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("dump_rd_valid", {15'd0, rspValid}, 16'd0);
            checkOutput("dump_rd_memWe", {15'd0, memWe}, 16'd0);
            tick();
            checkOutput("dump_rsp_valid", {15'd0, rspValid}, 16'd1);
            checkOutput("dump_rsp_word", {10'd0, rspAdd, rspData},
                        {10'd0, k[1:0], 4'(k + 1)});
            tick();
        end
        checkOutput("dump_done_busy", {15'd0, busy}, 16'd0);
        checkOutput("dump_done_cmdReady", {15'd0, cmdReady}, 16'd1);
        checkOutput("dump_done_rspValid", {15'd0, rspValid}, 16'd0);
        rspReady = 1'b0;
        useOverride = 1'b0;

        // FILL data=3 aborted by reset on its second cycle
        applyStimulus(1'b1, 2'b10, 2'd0, 4'h3);
        tick();
        applyStimulus(1'b0, 2'b00, 2'd0, 4'h0);
        checkOutput("abort_fill0", {12'd0, memWe, 1'b0, memAdd}, {12'd0, 1'b1, 1'b0, 2'd0});
        tick();
        checkOutput("abort_fill1", {12'd0, memWe, 1'b0, memAdd}, {12'd0, 1'b1, 1'b0, 2'd1});
        rst = 1'b1;
        #1;
        checkOutput("abort_memWe", {14'd0, memCe, memWe}, 16'd0);
        checkOutput("abort_busy", {15'd0, busy}, 16'd0);
        checkOutput("abort_cmdReady", {15'd0, cmdReady}, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("abort_regfile", tbRegFile, 16'h5553);
        checkOutput("abort_idle_memWe", {15'd0, memWe}, 16'd0);
        checkOutput("abort_idle_rspValid", {15'd0, rspValid}, 16'd0);
        checkOutput("abort_idle_cmdReady", {15'd0, cmdReady}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem4x4_ctrl.md
MEM4X4_CTRL -- requirements
Module: mem4x4_ctrl

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high; clock clk.
REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- cmdValid  in  1  host command valid
- cmdReady  out  1  command accepted when cmdValid and cmdReady are both high
- cmdOp  in  2  command: 00 WRITE, 01 READ, 10 FILL, 11 DUMP
- cmdAdd  in  2  target word address
- cmdData  in  4  write/fill data
- rspValid  out  1  response word valid
- rspReady  in  1  host takes response
- rspAdd  out  2  address of response word
- rspData  out  4  response word
- memCe  out  1  register-file chip enable
- memWe  out  1  register-file write enable
- memAdd  out  2  register-file address
- memDIn  out  4  register-file write data
- memDOut  in  16  register-file contents; word k at bits 4k+3..4k
- busy  out  1  high in every state except IDLE
REQ-003 The block SHALL drive the write port of a 4-word x 4-bit register file and consume its full-array read output.

Function
REQ-004 The FSM SHALL have these states: IDLE, WR, FILL, RD, RSP, DUMP_RD, DUMP_RSP.
REQ-005 cmdReady SHALL be high only in IDLE.
- On acceptance the block SHALL register op, add and data.
- The next state SHALL be WR, RD, FILL or DUMP_RD according to op.
- DUMP_RD SHALL be entered with counter=0.
REQ-006 WR SHALL last exactly one cycle.
- It SHALL drive memCe=1, memWe=1, memAdd=add and memDIn=data.
- It SHALL return to IDLE and produce no response.
REQ-007 FILL SHALL last exactly 4 cycles, writing data to addresses 0,1,2,3 in order.
- The 2-bit counter SHALL drive memAdd.
- When counter=3 the counter SHALL wrap to 0 and the FSM SHALL go to IDLE.
REQ-008 RD SHALL last one cycle.
- It SHALL capture word add of memDOut into rspData and set rspAdd=add.
- It SHALL go to RSP.
REQ-009 In RSP and DUMP_RSP, rspValid SHALL be 1.
- rspData and rspAdd SHALL hold stable until rspReady=1.
REQ-010 RSP SHALL go to IDLE on rspReady=1.
REQ-011 DUMP_RD SHALL capture word counter into rspData and set rspAdd=counter.
REQ-012 On rspReady=1, DUMP_RSP SHALL behave as follows:
- if counter=3, go to IDLE with the counter wrapped to 0;
- otherwise increment the counter and go to DUMP_RD.
REQ-013 Latency from the acceptance edge:
- WR strobe in the next cycle; cmdReady high again 2 cycles after acceptance.
- READ: rspValid high 2 cycles after acceptance.
- DUMP: at most one word per 2 cycles with rspReady held high.
REQ-014 Outside WR and FILL, memCe and memWe SHALL be 0.
REQ-015 In WR, FILL and IDLE, memAdd and memDIn SHALL show the registered add/counter and data; no value is required elsewhere.
REQ-016 cmdValid while busy=1 SHALL be ignored; the host holds the command until cmdReady.
REQ-017 rspReady while rspValid=0 SHALL be ignored.
REQ-018 cmdOp, cmdAdd and cmdData SHALL be sampled only at acceptance; later changes SHALL have no effect.
REQ-019 Reads SHALL return the register contents as of the RD/DUMP_RD cycle, including a write completed in the immediately preceding cycle.

Reset
REQ-020 While rst=1, all of the following SHALL be 0:
- state=IDLE, counter=0, registered op/add/data=0;
- cmdReady=0, busy=0, rspValid=0, rspAdd=0, rspData=0;
- memCe=0, memWe=0, memAdd=0, memDIn=0.
REQ-021 The first edge after rst release SHALL find the FSM in IDLE with cmdReady=1.
REQ-022 Reset asserted mid-WR, FILL or DUMP SHALL abort the operation immediately.
- No further write strobes or responses SHALL be issued.
- Register-file contents already written SHALL be left as they are.

Structure
REQ-023 A shared package SHALL hold these constants and types:
- word width 4, depth 4, address width 2;
- opcode constants WRITE/READ/FILL/DUMP;
- the FSM state enumeration.
REQ-024 The block SHALL be a single module with a registered state process and a combinational next-state/output decode.
- The word-select mux SHALL be inline.
- No sub-module is required.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- WRITE add=2 data=0xA -> one cycle memCe=1, memWe=1, memAdd=2, memDIn=0xA; cmdReady back after 2 cycles; no rspValid.
- READ add=2 with memDOut=0x0A00 -> rspValid=1, rspAdd=2, rspData=0xA; holds for 5 cycles of rspReady=0; clears the cycle after rspReady=1.
- FILL data=0x5 -> 4 consecutive write strobes to addresses 0,1,2,3 with memDIn=0x5; then IDLE.
- DUMP with memDOut=0x4321, rspReady=1 -> responses (0,1),(1,2),(2,3),(3,4); then IDLE; no repeated or skipped word.
- cmdValid held with READ during a FILL -> READ accepted only after FILL completes.
- rst pulse on the 2nd FILL cycle -> memWe=0 immediately; state IDLE; only address 0 written.
